// File: rtl/ysyx_23060191_gpr.sv
// General-purpose register file x0..x31 with a one-producer-per-register busy
// scoreboard, write-back bypass on both read ports and a registered wb_ready.
module ysyx_23060191_gpr #(
    parameter int CPU_WIDTH = 32,
    parameter int REG_AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [CPU_WIDTH-1:0] wb_data,
    output logic                 wb_ready,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_rd,
    output logic                 issue_ready,
    input  logic [REG_AW-1:0]    rs1_addr,
    input  logic [REG_AW-1:0]    rs2_addr,
    output logic [CPU_WIDTH-1:0] rs1_data,
    output logic [CPU_WIDTH-1:0] rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    localparam int NREG = 1 << REG_AW;

    // Handshakes: a write-back transfers on a rising edge with wb_valid && wb_ready;
    // a claim transfers with issue_valid && issue_ready. Neither side may retract.

    // x0 has no storage: arrays start at index 1.
    logic [CPU_WIDTH-1:0] regs_q [1:NREG-1];
    logic [CPU_WIDTH-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1]      busy_q;
    logic [NREG-1:1]      busy_d;
    logic                 wb_ready_q;
    logic                 wb_ready_d;

    logic                 wr_fire;
    logic                 claim_fire;
    logic                 issue_busy;
    logic [CPU_WIDTH-1:0] rs1_stored;
    logic [CPU_WIDTH-1:0] rs2_stored;
    logic                 rs1_busy_stored;
    logic                 rs2_busy_stored;
    logic                 rs1_hit;
    logic                 rs2_hit;

    assign wb_ready = wb_ready_q;
    assign wr_fire  = wb_valid && wb_ready_q && (wb_rd != '0);

    always_comb begin
        issue_busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (issue_rd == REG_AW'(i)) begin
                issue_busy = busy_q[i];
            end
        end
    end

    // A write retiring the current producer this cycle frees the register for a new claim.
    assign issue_ready = wb_ready_q &&
                         ((issue_rd == '0) || !issue_busy || (wr_fire && (wb_rd == issue_rd)));
    assign claim_fire  = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        rs1_stored      = '0;
        rs2_stored      = '0;
        rs1_busy_stored = 1'b0;
        rs2_busy_stored = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1_addr == REG_AW'(i)) begin
                rs1_stored      = regs_q[i];
                rs1_busy_stored = busy_q[i];
            end
            if (rs2_addr == REG_AW'(i)) begin
                rs2_stored      = regs_q[i];
                rs2_busy_stored = busy_q[i];
            end
        end
    end

    // wr_fire already excludes x0, so a hit never occurs for address 0.
    assign rs1_hit  = wr_fire && (wb_rd == rs1_addr);
    assign rs2_hit  = wr_fire && (wb_rd == rs2_addr);
    assign rs1_data = rs1_hit ? wb_data : rs1_stored;
    assign rs2_data = rs2_hit ? wb_data : rs2_stored;
    assign rs1_busy = rs1_busy_stored && !rs1_hit;
    assign rs2_busy = rs2_busy_stored && !rs2_hit;

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        wb_ready_d = 1'b1;
        for (int i = 1; i < NREG; i++) begin
            if (wr_fire && (wb_rd == REG_AW'(i))) begin
                regs_d[i] = wb_data;
                busy_d[i] = 1'b0;
            end
            // Set after clear: a same-edge claim wins over the retiring write.
            if (claim_fire && (issue_rd == REG_AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            wb_ready_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            wb_ready_q <= wb_ready_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_gpr.sv
// Randomized and directed bench for the register file, checked against an
// array-based model of the register/busy rules.
module tb_ysyx_23060191_gpr;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg [32];
    logic        m_busy [32];
    logic        m_ready;

    ysyx_23060191_gpr #(.CPU_WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_ready = 1'b0;
    endtask

    function automatic logic m_write_now();
        return wb_valid && m_ready && (wb_rd != 5'd0);
    endfunction

    function automatic logic m_issue_ready();
        return m_ready && ((issue_rd == 5'd0) || !m_busy[issue_rd] ||
                           (m_write_now() && wb_rd == issue_rd));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_write_now() && wb_rd == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_write_now() && wb_rd == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        check("wb_ready", {31'b0, wb_ready}, {31'b0, m_ready});
        check("issue_ready", {31'b0, issue_ready}, {31'b0, m_issue_ready()});
        check("rs1_data", rs1_data, m_read(rs1_addr));
        check("rs2_data", rs2_data, m_read(rs2_addr));
        check("rs1_busy", {31'b0, rs1_busy}, {31'b0, m_rbusy(rs1_addr)});
        check("rs2_busy", {31'b0, rs2_busy}, {31'b0, m_rbusy(rs2_addr)});
    endtask

    task automatic model_edge();
        logic wr;
        logic claim;
        if (rst) begin
            model_reset();
        end else begin
            wr    = m_write_now();
            claim = issue_valid && m_issue_ready() && (issue_rd != 5'd0);
            if (wr) begin
                m_reg[wb_rd]  = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (claim) m_busy[issue_rd] = 1'b1;
            m_ready = 1'b1;
        end
    endtask

    // inputs are set 1 time unit after a rising edge; outputs checked at the falling edge
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rd);
        issue_valid = v;
        issue_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_issue(1'b0, 5'd0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        model_reset();
        #1;
        check("rst_wb_ready", {31'b0, wb_ready}, 32'd0);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();

        // write x5 with same-cycle bypass, then stored value
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #2 check("x5_bypass", rs1_data, 32'hDEADBEEF);
        cycle();
        drive_wb(1'b0, 5'd0, 32'h0);
        #2 check("x5_stored", rs1_data, 32'hDEADBEEF);
        cycle();

        // write to x0 changes nothing
        drive_wb(1'b1, 5'd0, 32'h12345678);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        #2 check("x0_same_rs1", rs1_data, 32'h0);
        check("x0_same_rs2", rs2_data, 32'h0);
        cycle();
        drive_wb(1'b0, 5'd0, 32'h0);
        #2 check("x0_after", rs1_data, 32'h0);
        check("x0_busy", {31'b0, rs1_busy}, 32'd0);
        cycle();

        // claim x7, second claim stalls, write clears busy
        drive_issue(1'b1, 5'd7);
        rs2_addr = 5'd7;
        cycle();
        #2 check("x7_busy", {31'b0, rs2_busy}, 32'd1);
        check("x7_reclaim_stall", {31'b0, issue_ready}, 32'd0);
        cycle();
        drive_issue(1'b0, 5'd0);
        drive_wb(1'b1, 5'd7, 32'hA5A5A5A5);
        #2 check("x7_wr_busy", {31'b0, rs2_busy}, 32'd0);
        check("x7_wr_data", rs2_data, 32'hA5A5A5A5);
        cycle();
        drive_wb(1'b0, 5'd0, 32'h0);
        #2 check("x7_cleared", {31'b0, rs2_busy}, 32'd0);
        check("x7_data", rs2_data, 32'hA5A5A5A5);
        cycle();

        // same-edge write and claim of x9: set wins
        drive_wb(1'b1, 5'd9, 32'h11);
        drive_issue(1'b1, 5'd9);
        cycle();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_issue(1'b0, 5'd0);
        rs1_addr = 5'd9;
        #2 check("x9_data", rs1_data, 32'h11);
        check("x9_busy", {31'b0, rs1_busy}, 32'd1);
        cycle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            drive_wb(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
            drive_issue(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) rs1_addr = wb_rd;
            else rs1_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rs2_addr = rs1_addr;
            else rs2_addr = 5'($urandom_range(0, 31));
            cycle();
        end

        // async reset mid-cycle with a pending write to x4
        drive_issue(1'b0, 5'd0);
        drive_wb(1'b1, 5'd3, 32'hFFFFFFFF);
        cycle();
        drive_wb(1'b1, 5'd4, 32'h44444444);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("arst_wb_ready", {31'b0, wb_ready}, 32'd0);
        check("arst_issue_ready", {31'b0, issue_ready}, 32'd0);
        check("arst_x3", rs1_data, 32'h0);
        check("arst_x4", rs2_data, 32'h0);
        check("arst_busy", {30'b0, rs1_busy, rs2_busy}, 32'd0);
        cycle();
        rst = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        cycle();
        #2 check("arst_ready_back", {31'b0, wb_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_gpr.md
YSYX_23060191_GPR -- requirements
Module: ysyx_23060191_GPR

Interface
REQ-001 Parameter: CPU_WIDTH, 32, data width of each general-purpose register.
REQ-002 Parameter: REG_AW, 5, register address width (32 registers, x0..x31).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wb_valid  input  1  write-back request from the write-back stage.
REQ-006 wb_rd  input  REG_AW  destination register of the write-back.
REQ-007 wb_data  input  CPU_WIDTH  write-back data (the write-back stage's data_wr_Rd).
REQ-008 wb_ready  output  1  register file can accept a write-back this cycle.
REQ-009 issue_valid  input  1  decode stage issuing an instruction that will write issue_rd.
REQ-010 issue_rd  input  REG_AW  destination register being claimed.
REQ-011 issue_ready  output  1  claim accepted this cycle (combinational).
REQ-012 rs1_addr, rs2_addr  input  REG_AW each  read port addresses.
REQ-013 rs1_data, rs2_data  output  CPU_WIDTH each  read data (combinational, with bypass).
REQ-014 rs1_busy, rs2_busy  output  1 each  source register has an outstanding, not-yet-written producer.

Function
REQ-015 The block SHALL hold 31 CPU_WIDTH-bit registers x1..x31 plus a 31-bit busy scoreboard; x0 SHALL have no storage.
REQ-016 Write handshake: a write SHALL occur on a rising edge where wb_valid && wb_ready && wb_rd != 0; wb_data SHALL be stored in register wb_rd.
REQ-017 wb_ready SHALL be a flop: 0 while rst is asserted, 1 from the first rising edge after rst deassertion onward.
REQ-018 Writes with wb_rd == 0 SHALL complete the handshake and change no state.
REQ-019 A completed write SHALL clear busy[wb_rd] on the same edge.
REQ-020 issue_ready SHALL be 1 when wb_ready is 1 and (issue_rd == 0, or busy[issue_rd] == 0, or a write to issue_rd completes this cycle); otherwise 0.
REQ-021 An issue claim SHALL complete on an edge where issue_valid && issue_ready; for issue_rd != 0, busy[issue_rd] SHALL be set.
REQ-022 When write and claim complete on the same edge for the same nonzero register, set SHALL win (busy ends 1, data updated).
REQ-023 Read data SHALL be combinational, zero-latency: address 0 returns 0.
REQ-024 Read bypass: when wb_valid && wb_ready && wb_rd == rsN_addr != 0, rsN_data SHALL equal wb_data; otherwise it SHALL be the stored value.
REQ-025 rsN_busy SHALL be busy[rsN_addr], forced to 0 when rsN_addr == 0 or when a bypassed write to that address is present this cycle.
REQ-026 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data and busy.
REQ-027 At most one outstanding producer per register SHALL exist; the issue_ready gating of REQ-020 guarantees this, and no counter is kept.
REQ-028 Issue of a register already busy, with no same-cycle write, SHALL stall (issue_ready 0) with no state change until the write completes.

Reset
REQ-029 While rst is 1 (asynchronously): x1..x31 SHALL be 0, all busy bits 0, wb_ready 0, hence issue_ready 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending write and all claims; no write SHALL occur on the edge coinciding with rst high.
REQ-031 After reset deassertion, all reads SHALL return 0 and all busy outputs SHALL be 0.

Verification
REQ-032 Reset then write x5=0xDEADBEEF (wb_valid, wb_rd=5) -> same cycle rs1_addr=5 reads 0xDEADBEEF via bypass; next cycle stored value 0xDEADBEEF.
REQ-033 Write x0=0x12345678 -> rs1_addr=0, rs2_addr=0 read 0x00000000 in same and subsequent cycles; busy 0.
REQ-034 Claim x7 (issue_valid, issue_rd=7) -> next cycle rs2_busy=1 for rs2_addr=7, second claim of x7 sees issue_ready=0; write x7=0xA5A5A5A5 -> rs2_busy=0 and data 0xA5A5A5A5 same cycle, busy cleared next cycle.
REQ-035 Same-edge write and claim of x9 (wb_data=0x11) -> x9 reads 0x11 and busy[9]=1 afterwards.
REQ-036 Write x3=0xFFFFFFFF, assert rst asynchronously mid-cycle with wb_valid on x4 -> x3 reads 0, x4 reads 0, wb_ready 0 immediately, all busy 0; wb_ready returns 1 one edge after deassertion.
